aibcr3_dcc_cal_ctrl: RTL and testbench

Calibration controller that closes the DCC/DLL loop. It drives the launch/measure stimulus into the DCC delay line and samples the phase detector's t_up/t_down decisions. It runs an 11-bit successive-approximation search followed by ±1 tracking, and delivers the Gray-coded delay code (i_gray/f_gray) and dll_lock to the downstream delay-line block. It sits directly upstream of the DLL/DCC custom macro and consumes its t_up/t_down outputs.

---
 rtl/aibcr3_dcc_cal_ctrl.sv | 161 ++++++++++++++++
 tb/tb_aibcr3_dcc_cal_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aibcr3_dcc_cal_ctrl.sv
// DCC/DLL calibration controller: 11-bit SAR search on phase-detector decisions, then +/-1 tracking until lock.
// Emits launch/measure stimulus per step and a registered Gray-coded delay code.
module aibcr3_dcc_cal_ctrl #(
  parameter int SETTLE_CYC   = 16,
  parameter int MAX_RETRY    = 3,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic        clk_dcd,
  input  logic        nrst,
  input  logic        cal_start,
  input  logic        t_up,
  input  logic        t_down,
  output logic        pd_rst_n,
  output logic        launch,
  output logic        measure,
  output logic [2:0]  i_gray,
  output logic [7:0]  f_gray,
  output logic        dll_lock,
  output logic        cal_busy,
  output logic        cal_err,
  output logic [10:0] cal_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LAUNCH, S_MEAS, S_SETTLE, S_DECIDE, S_LOCKED
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  up_sync, down_sync;
  logic        up_s, down_s, is_up, is_dn, is_none;
  logic [10:0] code, code_nxt, gray_q;
  logic [3:0]  idx, idx_nxt, toggles, toggles_nxt;
  logic [7:0]  retry, retry_nxt, settle_cnt;
  logic        track, track_nxt, prev_vld, prev_vld_nxt, prev_up, prev_up_nxt;
  logic        err, err_nxt, lock_now;

  always_ff @(posedge clk_dcd) begin
    if (!nrst) begin
      up_sync   <= '0;
      down_sync <= '0;
    end else begin
      up_sync   <= {up_sync[0], t_up};
      down_sync <= {down_sync[0], t_down};
    end
  end

  assign up_s    = up_sync[1];
  assign down_s  = down_sync[1];
  assign is_up   = up_s & ~down_s;
  assign is_dn   = down_s & ~up_s;
  assign is_none = ~(is_up | is_dn);

  // Decision datapath; only DECIDE changes anything.
  always_comb begin
    code_nxt     = code;
    idx_nxt      = idx;
    retry_nxt    = retry;
    toggles_nxt  = toggles;
    track_nxt    = track;
    prev_vld_nxt = prev_vld;
    prev_up_nxt  = prev_up;
    err_nxt      = err;
    if (state == S_DECIDE) begin
      if (!track) begin
        if (is_up || is_dn || retry == 8'(MAX_RETRY - 1)) begin
          code_nxt[idx] = is_up;
          retry_nxt     = '0;
          if (idx != 4'd0) begin
            idx_nxt                = idx - 4'd1;
            code_nxt[idx - 4'd1]   = 1'b1;
          end else begin
            track_nxt    = 1'b1;
            prev_vld_nxt = 1'b0;
            toggles_nxt  = '0;
          end
        end else begin
          retry_nxt = retry + 8'd1;
        end
      end else if (!is_none) begin
        if ((is_up && code == 11'h7FF) || (is_dn && code == 11'h000)) begin
          err_nxt     = 1'b1;
          toggles_nxt = '0;
        end else begin
          code_nxt    = is_up ? code + 11'd1 : code - 11'd1;
          toggles_nxt = (prev_vld && prev_up != is_up) ? toggles + 4'd1 : 4'd0;
        end
        prev_vld_nxt = 1'b1;
        prev_up_nxt  = is_up;
      end
    end
  end

  assign lock_now = (state == S_DECIDE) && track && (toggles_nxt == 4'(LOCK_TOGGLES));

  always_ff @(posedge clk_dcd) begin
    if (!nrst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!cal_start) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_CLR;
        S_CLR:    state_nxt = S_LAUNCH;
        S_LAUNCH: state_nxt = S_MEAS;
        S_MEAS:   state_nxt = S_SETTLE;
        S_SETTLE: if (settle_cnt == 8'(SETTLE_CYC - 1)) state_nxt = S_DECIDE;
        S_DECIDE: state_nxt = lock_now ? S_LOCKED : S_CLR;
        S_LOCKED: state_nxt = S_LOCKED;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pd_rst_n = !(state == S_IDLE || state == S_CLR);
    launch   = (state == S_LAUNCH);
    measure  = (state == S_MEAS);
    dll_lock = (state == S_LOCKED);
    cal_busy = (state != S_IDLE) && (state != S_LOCKED);
  end

  // Dropping cal_start clears the search context but keeps the sticky error.
  always_ff @(posedge clk_dcd) begin
    if (!nrst) begin
      code <= '0; idx <= 4'd10; retry <= '0; toggles <= '0;
      track <= 1'b0; prev_vld <= 1'b0; prev_up <= 1'b0; err <= 1'b0;
    end else if (!cal_start) begin
      code <= '0; idx <= 4'd10; retry <= '0; toggles <= '0;
      track <= 1'b0; prev_vld <= 1'b0;
    end else if (state == S_IDLE) begin
      code <= 11'h400; idx <= 4'd10; retry <= '0; toggles <= '0;
      track <= 1'b0; prev_vld <= 1'b0; err <= 1'b0;
    end else begin
      code <= code_nxt; idx <= idx_nxt; retry <= retry_nxt; toggles <= toggles_nxt;
      track <= track_nxt; prev_vld <= prev_vld_nxt; prev_up <= prev_up_nxt; err <= err_nxt;
    end
  end

  always_ff @(posedge clk_dcd) begin
    if (!nrst) begin
      settle_cnt <= '0;
      gray_q     <= '0;
    end else begin
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      gray_q     <= code ^ (code >> 1);
    end
  end

  assign i_gray   = gray_q[2:0];
  assign f_gray   = gray_q[10:3];
  assign cal_code = code;
  assign cal_err  = err;

endmodule

// File: tb/tb_aibcr3_dcc_cal_ctrl.sv
// Bench for aibcr3_dcc_cal_ctrl: closed-loop threshold detector model, randomized thresholds,
// directed reset/saturation/no-decision/abort cases, and step timing on a SETTLE_CYC=3 instance.
module tb_aibcr3_dcc_cal_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst, cal_start, t_up, t_down;
  logic pd_rst_n, launch, measure, dll_lock, cal_busy, cal_err;
  logic [2:0] i_gray;
  logic [7:0] f_gray;
  logic [10:0] cal_code;
  logic pd_rst_n_3, launch_3, measure_3, dll_lock_3, cal_busy_3, cal_err_3;
  logic [2:0] i_gray_3;
  logic [7:0] f_gray_3;
  logic [10:0] cal_code_3;

  aibcr3_dcc_cal_ctrl dut (
    .clk_dcd(clk), .nrst(nrst), .cal_start(cal_start), .t_up(t_up), .t_down(t_down),
    .pd_rst_n(pd_rst_n), .launch(launch), .measure(measure), .i_gray(i_gray), .f_gray(f_gray),
    .dll_lock(dll_lock), .cal_busy(cal_busy), .cal_err(cal_err), .cal_code(cal_code));

  aibcr3_dcc_cal_ctrl #(.SETTLE_CYC(3)) dut3 (
    .clk_dcd(clk), .nrst(nrst), .cal_start(cal_start), .t_up(t_up), .t_down(t_down),
    .pd_rst_n(pd_rst_n_3), .launch(launch_3), .measure(measure_3), .i_gray(i_gray_3), .f_gray(f_gray_3),
    .dll_lock(dll_lock_3), .cal_busy(cal_busy_3), .cal_err(cal_err_3), .cal_code(cal_code_3));

  int total = 0;
  int bad   = 0;
  int thr   = 1000;
  bit det_none  = 1'b0;
  bit always_up = 1'b0;

  // Detector model: "delay too short" while the code is below the threshold.
  always @(negedge clk) begin
    bit b;
    if (det_none) begin
      b = 1'($urandom_range(0, 1));
      t_up = b;
      t_down = b;
    end else if (always_up) begin
      t_up = 1'b1;
      t_down = 1'b0;
    end else begin
      t_up = (int'(cal_code) < thr);
      t_down = !(int'(cal_code) < thr);
    end
  end

  function automatic logic [10:0] gray(input logic [10:0] c);
    return c ^ (c >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pd_rst_n"}, 32'(pd_rst_n), 0);
    chk({tag, "_launch"},   32'(launch), 0);
    chk({tag, "_measure"},  32'(measure), 0);
    chk({tag, "_dll_lock"}, 32'(dll_lock), 0);
    chk({tag, "_cal_busy"}, 32'(cal_busy), 0);
    chk({tag, "_cal_err"},  32'(cal_err), 0);
    chk({tag, "_cal_code"}, 32'(cal_code), 0);
    chk({tag, "_i_gray"},   32'(i_gray), 0);
    chk({tag, "_f_gray"},   32'(f_gray), 0);
  endtask

  // One SAR step is 20 cycles at SETTLE_CYC=16; 11 SAR steps plus 5 tracking steps reach lock.
  task automatic run_conv(input int t, input bit timing);
    logic [10:0] lock_code;
    thr = t;
    cal_start = 1'b1;
    for (int c = 1; c <= 321; c++) begin
      tick(1);
      if (timing && c <= 40) begin
        chk("step_pd_low", 32'(!pd_rst_n_3), 32'((c - 1) % 7 == 0));
        chk("step_launch", 32'(launch_3), 32'(c >= 2 && (c - 2) % 7 == 0));
        chk("step_measure", 32'(measure_3), 32'(c >= 3 && (c - 3) % 7 == 0));
      end
      if (c == 221) chk("sar_result", 32'(cal_code), 32'(t - 1));
      if (c == 320) chk("no_early_lock", 32'(dll_lock), 0);
    end
    lock_code = 11'(t);
    chk("lock", 32'(dll_lock), 1);
    chk("lock_code", 32'(cal_code), 32'(lock_code));
    chk("lock_busy", 32'(cal_busy), 0);
    chk("lock_err", 32'(cal_err), 0);
    tick(1);
    chk("lock_f_gray", 32'(f_gray), 32'(gray(lock_code) >> 3));
    chk("lock_i_gray", 32'(i_gray), 32'(gray(lock_code) & 11'h7));
    cal_start = 1'b0;
    tick(1);
    chk("unlock_on_idle", 32'(dll_lock), 0);
    chk("idle_busy", 32'(cal_busy), 0);
    tick(1);
  endtask

  initial begin
    bit seen;
    int t;
    nrst = 1'b0;
    cal_start = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    nrst = 1'b1;
    tick(2);

    // Reset asserted while SETTLE is in progress on the first step.
    cal_start = 1'b1;
    tick(5);
    chk("pre_reset_code", 32'(cal_code), 32'h400);
    chk("pre_reset_busy", 32'(cal_busy), 1);
    nrst = 1'b0;
    tick(1);
    check_reset_outputs("mid_reset");
    cal_start = 1'b0;
    nrst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen |= launch;
    end
    chk("no_launch_after_reset", 32'(seen), 0);

    run_conv(1000, 1'b1);
    for (int r = 0; r < 3; r++) begin
      t = int'($urandom_range(1, 2047));
      run_conv(t, 1'b0);
    end

    // Detector stuck "up": SAR saturates high and tracking flags the error.
    always_up = 1'b1;
    cal_start = 1'b1;
    tick(221);
    chk("sat_sar", 32'(cal_code), 32'h7FF);
    chk("sat_err_before", 32'(cal_err), 0);
    tick(20);
    chk("sat_err", 32'(cal_err), 1);
    chk("sat_code_held", 32'(cal_code), 32'h7FF);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      seen |= dll_lock;
    end
    chk("sat_no_lock", 32'(seen), 0);
    cal_start = 1'b0;
    tick(2);
    chk("err_retained_idle", 32'(cal_err), 1);
    always_up = 1'b0;

    // Abort during SETTLE of the idx=5 step.
    thr = 1000;
    cal_start = 1'b1;
    tick(1);
    chk("restart_clears_err", 32'(cal_err), 0);
    tick(105);
    chk("abort_busy_before", 32'(cal_busy), 1);
    chk("abort_code_idx5", 32'(cal_code), 32'(((thr - 1) & 32'h7C0) | 32'h020));
    cal_start = 1'b0;
    tick(1);
    chk("abort_busy", 32'(cal_busy), 0);
    chk("abort_pd_rst_n", 32'(pd_rst_n), 0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen |= measure;
    end
    chk("abort_no_measure", 32'(seen), 0);
    cal_start = 1'b1;
    tick(1);
    chk("abort_restart_code", 32'(cal_code), 32'h400);
    chk("abort_restart_err", 32'(cal_err), 0);
    cal_start = 1'b0;
    tick(2);

    // Two no-decision samples, then up: bit 10 survives on the third step.
    thr = 2000;
    det_none = 1'b1;
    cal_start = 1'b1;
    tick(20);
    chk("none1_code", 32'(cal_code), 32'h400);
    tick(20);
    det_none = 1'b0;
    tick(1);
    chk("none2_code", 32'(cal_code), 32'h400);
    tick(20);
    chk("none2_then_up", 32'(cal_code), 32'h600);
    cal_start = 1'b0;
    tick(2);

    // Three no-decision samples resolve the bit as down.
    det_none = 1'b1;
    cal_start = 1'b1;
    tick(60);
    det_none = 1'b0;
    tick(1);
    chk("none3_cleared", 32'(cal_code), 32'h200);
    cal_start = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
